p_line_burst_adaptor: RTL
=========================

P_LINE_BURST_ADAPTOR -- requirements
Module: p_line_burst_adaptor

Interface
REQ-001 SHALL have parameter s_line, default 256, meaning cache-line width in bits.
REQ-002 SHALL have parameter s_burst, default 64, meaning memory beat width in bits; BEATS = s_line/s_burst, power of 2, >= 2 (4 at defaults).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port pmem_read  input  1  cache-side line read request, held until pmem_resp.
REQ-006 SHALL have port pmem_write  input  1  cache-side line write request, held until pmem_resp.
REQ-007 SHALL have port pmem_address  input  32  cache-side byte address.
REQ-008 SHALL have port pmem_wdata  input  s_line  line to write.
REQ-009 SHALL have port pmem_rdata  output  s_line  assembled read line.
REQ-010 SHALL have port pmem_resp  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port burst_address  output  32  line-aligned memory address.
REQ-012 SHALL have port burst_read / burst_write  output  1 each  memory burst request.
REQ-013 SHALL have port burst_rdata  input  s_burst  read beat; burst_wdata  output  s_burst  write beat.
REQ-014 SHALL have port burst_resp  input  1  marks one accepted/valid beat.

Function
REQ-015 SHALL implement FSM IDLE, READ_BURST, WRITE_BURST, RESP.
REQ-016 IDLE: pmem_write -> WRITE_BURST; else pmem_read -> READ_BURST; both asserted: write served, read stays pending.
REQ-017 On acceptance SHALL latch pmem_address with low log2(s_line/8) bits zeroed into burst_address, latch pmem_wdata, clear beat counter.
REQ-018 burst_read/burst_write SHALL be high continuously from cycle after acceptance until cycle of final beat's burst_resp, inclusive.
REQ-019 Beats SHALL be ordered low-to-high: beat k maps to line bits [k*s_burst +: s_burst].
REQ-020 READ_BURST: each burst_resp cycle SHALL store burst_rdata into slot k, increment counter; gaps between beats allowed.
REQ-021 WRITE_BURST: burst_wdata SHALL present slot k until burst_resp, then advance to k+1.
REQ-022 Final beat -> RESP; RESP asserts pmem_resp one cycle with full line on pmem_rdata, then IDLE.
REQ-023 pmem_rdata SHALL hold last assembled line until next read completes.
REQ-024 Request still asserted in IDLE the cycle after pmem_resp SHALL be treated as new request.
REQ-025 burst_resp in IDLE/RESP SHALL be ignored; counter wraps only via explicit clear, never past BEATS-1.
REQ-026 Default latency (no stall beats): acceptance cycle + BEATS beats + 1 RESP cycle.

Reset
REQ-027 Reset SHALL force IDLE, counter 0, pmem_resp 0, burst_read 0, burst_write 0, burst_address 0, pmem_rdata 0, burst_wdata 0.
REQ-028 Reset mid-burst SHALL abort: partial line discarded, burst requests low next cycle, no pmem_resp issued.

Configuration
REQ-029 Macro ADAPTOR_EARLY_RESP_EN defined: RESP state removed; pmem_resp asserted combinationally in final-beat burst_resp cycle, pmem_rdata = buffered beats plus live burst_rdata in top slot; saves one cycle.
REQ-030 Macro undefined: registered RESP behaviour per REQ-022; pmem_resp and pmem_rdata purely registered.

Verification
REQ-031 Read 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. consecutive -> burst_address 0x0000_1220, pmem_rdata = {0x44..,0x33..,0x22..,0x11..}, pmem_resp one pulse.
REQ-032 Write line 0xDDDD..CCCC..BBBB..AAAA, burst_resp with 2-cycle gaps -> burst_wdata AAAA,BBBB,CCCC,DDDD each held until its resp; single pmem_resp.
REQ-033 pmem_read and pmem_write asserted same cycle -> write burst completes first, then read burst starts cycle after pmem_resp.
REQ-034 rst after beat 2 of read -> burst_read 0 next cycle, no pmem_resp, following read returns only new beats.
REQ-035 Spurious burst_resp in IDLE -> no state change, counter stays 0.
REQ-036 Both macro settings: back-to-back reads latency 6 cycles (undefined) vs 5 (defined), identical data.

Source files
------------

// File: rtl/p_line_burst_adaptor.sv
// Splits cache-line reads/writes into s_line/s_burst memory beats, ordered low beat first.
// Define ADAPTOR_EARLY_RESP_EN to drop the RESP state and respond during the final beat.
module p_line_burst_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [31:0]        pmem_address,
  input  logic [s_line-1:0]  pmem_wdata,
  output logic [s_line-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        burst_address,
  output logic               burst_read,
  output logic               burst_write,
  input  logic [s_burst-1:0] burst_rdata,
  output logic [s_burst-1:0] burst_wdata,
  input  logic               burst_resp
);

  localparam int          BEATS     = s_line / s_burst;
  localparam int          CW        = $clog2(BEATS);
  localparam logic [31:0] ADDR_MASK = ~32'(s_line / 8 - 1);

  typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_count;
  logic [31:0]         r_addr;
  logic [s_line-1:0]   r_wdata;
  logic [s_line-1:0]   r_buf;
  logic [s_line-1:0]   r_rdata;
  logic [s_line-1:0]   w_assembled;
  logic                w_accept;
  logic                w_beat;
  logic                w_last;
  int                  w_base;

  assign w_accept = (r_state == IDLE) && (pmem_read || pmem_write);
  assign w_beat   = burst_resp && ((r_state == READ_BURST) || (r_state == WRITE_BURST));
  assign w_last   = w_beat && (r_count == CW'(BEATS - 1));
  assign w_base   = int'(r_count) * s_burst;

  // Buffered beats with the live beat dropped into the current slot.
  always_comb begin
    w_assembled = r_buf;
    w_assembled[w_base +: s_burst] = burst_rdata;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (pmem_write)     w_next = WRITE_BURST;
        else if (pmem_read) w_next = READ_BURST;
      end
      READ_BURST, WRITE_BURST: begin
`ifdef ADAPTOR_EARLY_RESP_EN
        if (w_last) w_next = IDLE;
`else
        if (w_last) w_next = RESP;
`endif
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= pmem_address & ADDR_MASK;
        r_wdata <= pmem_wdata;
        r_count <= '0;
      end else if (w_beat) begin
        r_count <= w_last ? '0 : r_count + CW'(1);
        if (r_state == READ_BURST) begin
          r_buf <= w_assembled;
          if (w_last) r_rdata <= w_assembled;
        end
      end
    end
  end

  assign burst_address = r_addr;
  assign burst_read    = (r_state == READ_BURST);
  assign burst_write   = (r_state == WRITE_BURST);
  assign burst_wdata   = r_wdata[w_base +: s_burst];

`ifdef ADAPTOR_EARLY_RESP_EN
  assign pmem_resp  = w_last;
  assign pmem_rdata = (w_last && (r_state == READ_BURST)) ? w_assembled : r_rdata;
`else
  assign pmem_resp  = (r_state == RESP);
  assign pmem_rdata = r_rdata;
`endif

endmodule
